// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI word width, idle word and slave FSM state encoding
package spi_pkg;
  localparam int SPI_WIDTH = 8;
  localparam logic [SPI_WIDTH-1:0] SPI_IDLE_WORD = 8'hFF;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
endpackage

// File: rtl/spi_sl_if.sv
// spi_sl_if: SPI pins plus local tx/rx handshake of the SPI slave
// slave modport: cs/sck/mosi/tx_data/tx_wr in; miso/tx_ready/rx_*/tx_underrun/busy out
interface spi_sl_if import spi_pkg::*; #(parameter int WIDTH = SPI_WIDTH) ();
  logic cs, sck, mosi, miso;
  logic [WIDTH-1:0] tx_data, rx_data;
  logic tx_wr, tx_ready, rx_valid, rx_abort, tx_underrun, busy;
  modport slave (input cs, sck, mosi, tx_data, tx_wr,
                 output miso, tx_ready, rx_data, rx_valid, rx_abort, tx_underrun, busy);
  modport master (output cs, sck, mosi, tx_data, tx_wr,
                  input miso, tx_ready, rx_data, rx_valid, rx_abort, tx_underrun, busy);
endinterface

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: SYNC_STAGES-deep synchroniser with rise/fall detect on the last two samples
// ports: clk, rst_n (sync, active low), i_d async in, o_q synced out, o_rise/o_fall one-cycle edges
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic r_prev;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync <= {SYNC_STAGES{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end
  assign o_q    = r_sync[SYNC_STAGES-1];
  assign o_rise = o_q & ~r_prev;
  assign o_fall = ~o_q & r_prev;
endmodule

// File: rtl/spi_sl.sv
// spi_sl: SPI mode-0 MSB-first slave with 1-deep tx holding register and rx pulse outputs
// ports: clk, rst_n (sync, active low), bus (spi_sl_if.slave: SPI pins + tx/rx handshake)
module spi_sl import spi_pkg::*; #(
  parameter int               WIDTH       = SPI_WIDTH,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] IDLE_WORD   = SPI_IDLE_WORD
) (
  input logic   clk,
  input logic   rst_n,
  spi_sl_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam int FW = $clog2(SYNC_STAGES + 2);
  state_t r_state, w_next;
  logic [WIDTH-1:0] r_hold, r_tx_shift, r_rx_shift, r_rx_data, w_load, w_rx_word;
  logic [CW-1:0] r_bit_cnt;
  logic [FW-1:0] r_flush;
  logic r_full, r_word_done, r_miso, r_rx_valid, r_rx_abort, r_tx_underrun;
  logic w_cs_q, w_cs_rise, w_cs_fall, w_sck_q, w_sck_rise, w_sck_fall, w_mosi;
  logic w_unused_cs_q, w_unused_sck_q, w_unused_mosi_rise, w_unused_mosi_fall;
  logic w_start, w_boundary, w_consume, w_wr, w_last;
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .clk(clk), .rst_n(rst_n), .i_d(bus.cs), .o_q(w_cs_q), .o_rise(w_cs_rise), .o_fall(w_cs_fall));
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
    .clk(clk), .rst_n(rst_n), .i_d(bus.sck), .o_q(w_sck_q), .o_rise(w_sck_rise), .o_fall(w_sck_fall));
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
    .clk(clk), .rst_n(rst_n), .i_d(bus.mosi), .o_q(w_mosi), .o_rise(w_unused_mosi_rise), .o_fall(w_unused_mosi_fall));
  assign w_unused_cs_q  = w_cs_q;
  assign w_unused_sck_q = w_sck_q;
  // A reset in mid-transfer leaves cs low at the pins; the synchroniser then shows a
  // cs fall once it flushes, so cs_fall is ignored until that flush window has passed.
  assign w_start    = w_cs_fall && r_flush == '0;
  assign w_last     = r_bit_cnt == CW'(WIDTH - 1);
  assign w_boundary = r_state == SHIFT && !w_cs_rise && w_sck_fall && r_bit_cnt == '0 && r_word_done;
  assign w_consume  = r_state == LOAD || w_boundary;
  assign w_wr       = bus.tx_wr && !r_full;
  assign w_load     = r_full ? r_hold : IDLE_WORD;
  assign w_rx_word  = {r_rx_shift[WIDTH-2:0], w_mosi};
  always_ff @(posedge clk) r_state <= !rst_n ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    w_next = r_state == IDLE ? (w_start ? LOAD : IDLE) :
             r_state == LOAD ? SHIFT : (w_cs_rise ? IDLE : SHIFT);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hold        <= '0;
      r_full        <= 1'b0;
      r_tx_shift    <= '0;
      r_rx_shift    <= '0;
      r_rx_data     <= '0;
      r_bit_cnt     <= '0;
      r_word_done   <= 1'b0;
      r_miso        <= 1'b0;
      r_rx_valid    <= 1'b0;
      r_rx_abort    <= 1'b0;
      r_tx_underrun <= 1'b0;
      r_flush       <= FW'(SYNC_STAGES + 1);
    end else begin
      r_rx_valid    <= 1'b0;
      r_rx_abort    <= 1'b0;
      r_tx_underrun <= w_consume && !r_full;
      // a consume on an empty register still lets a same-cycle write land
      r_full        <= w_wr || (r_full && !w_consume);
      if (w_wr) r_hold <= bus.tx_data;
      if (r_flush != '0) r_flush <= r_flush - 1'b1;
      if (w_consume) begin
        r_tx_shift  <= w_load;
        r_miso      <= w_load[WIDTH-1];
        r_bit_cnt   <= '0;
        r_word_done <= 1'b0;
      end else if (r_state == SHIFT) begin
        if (w_cs_rise) begin
          r_rx_abort <= r_bit_cnt != '0;
          r_miso     <= 1'b0;
          r_bit_cnt  <= '0;
        end else if (w_sck_rise) begin
          r_rx_shift  <= w_rx_word;
          r_bit_cnt   <= w_last ? '0 : r_bit_cnt + 1'b1;
          r_word_done <= r_word_done | w_last;
          if (w_last) begin
            r_rx_data  <= w_rx_word;
            r_rx_valid <= 1'b1;
          end
        end else if (w_sck_fall && r_bit_cnt != '0) begin
          r_tx_shift <= r_tx_shift << 1;
          r_miso     <= r_tx_shift[WIDTH-2];
        end
      end else begin
        r_miso <= 1'b0;
      end
    end
  end
  assign bus.miso        = r_miso;
  assign bus.tx_ready    = ~r_full;
  assign bus.rx_data     = r_rx_data;
  assign bus.rx_valid    = r_rx_valid;
  assign bus.rx_abort    = r_rx_abort;
  assign bus.tx_underrun = r_tx_underrun;
  assign bus.busy        = r_state == SHIFT;
endmodule
